hazard_forwarding_unit: RTL and testbench

- Consumer-side controller for the ID/EX pipeline register.
- Generates the NOP/clear that feeds ID/EX, the load enables for PC and IF/ID, and the operand-forwarding selects used in ID.
- Keeps its own shadow pipeline of destination-register tags for the EX, MEM and WB stages. It resolves RAW hazards by forwarding where possible and by stalling on load-use.

---
 rtl/hazard_forwarding_unit.sv | 179 +++++++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// RAW hazard control for ID: shadow EX/MEM/WB destination tags drive same-cycle forward selects,
// load-use stalls (PC/IF-ID hold plus ID/EX bubble) and flush bubbles; tags advance one stage per clock.
module hazard_forwarding_unit #(
    parameter int REG_W             = 4,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rs,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_RF_enable,
    input  logic             ID_load_instr,
    input  logic             flush,
    output logic [1:0]       FW_A,
    output logic [1:0]       FW_B,
    output logic [1:0]       FW_C,
    output logic             LE_PC,
    output logic             LE_IF_ID,
    output logic             NOP_ID_EX,
    output logic             stall
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             ex_v, mem_v, wb_v;
    logic             ex_ld;
    logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;

    logic ex_hit_a, ex_hit_b, ex_hit_c;
    logic mem_hit_a, mem_hit_b, mem_hit_c;
    logic wb_hit_a, wb_hit_b, wb_hit_c;
    logic load_use;

    logic [1:0] fw_a_raw, fw_b_raw, fw_c_raw;
    logic       le_pc_raw, le_if_id_raw, nop_raw, stall_raw;

    // Shadow tag pipeline; a bubble into EX is just a cleared valid bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ex_v   <= 1'b0;
            ex_rd  <= '0;
            ex_ld  <= 1'b0;
            mem_v  <= 1'b0;
            mem_rd <= '0;
            wb_v   <= 1'b0;
            wb_rd  <= '0;
        end else begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            if (NOP_ID_EX) begin
                ex_v  <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_v  <= ID_RF_enable;
                ex_rd <= ID_Rd;
                ex_ld <= ID_load_instr;
            end
        end
    end

    assign ex_hit_a  = ID_use_Rn && ex_v  && (ex_rd  == ID_Rn);
    assign ex_hit_b  = ID_use_Rm && ex_v  && (ex_rd  == ID_Rm);
    assign ex_hit_c  = ID_use_Rs && ex_v  && (ex_rd  == ID_Rs);
    assign mem_hit_a = ID_use_Rn && mem_v && (mem_rd == ID_Rn);
    assign mem_hit_b = ID_use_Rm && mem_v && (mem_rd == ID_Rm);
    assign mem_hit_c = ID_use_Rs && mem_v && (mem_rd == ID_Rs);
    assign wb_hit_a  = ID_use_Rn && wb_v  && (wb_rd  == ID_Rn);
    assign wb_hit_b  = ID_use_Rm && wb_v  && (wb_rd  == ID_Rm);
    assign wb_hit_c  = ID_use_Rs && wb_v  && (wb_rd  == ID_Rs);

    // A load in EX has no data yet, so its hit falls through to older stages.
    assign fw_a_raw = (ex_hit_a && !ex_ld) ? SEL_EX :
                      mem_hit_a            ? SEL_MEM :
                      wb_hit_a             ? SEL_WB : SEL_RF;
    assign fw_b_raw = (ex_hit_b && !ex_ld) ? SEL_EX :
                      mem_hit_b            ? SEL_MEM :
                      wb_hit_b             ? SEL_WB : SEL_RF;
    assign fw_c_raw = (ex_hit_c && !ex_ld) ? SEL_EX :
                      mem_hit_c            ? SEL_MEM :
                      wb_hit_c             ? SEL_WB : SEL_RF;

    assign load_use = ex_ld && (ex_hit_a || ex_hit_b || ex_hit_c);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        le_pc_raw    = 1'b1;
        le_if_id_raw = 1'b1;
        nop_raw      = 1'b0;
        stall_raw    = 1'b0;
        if (flush) begin
            // Squashing ID also cancels any pending stall sequence.
            nop_raw   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        le_pc_raw    = 1'b0;
                        le_if_id_raw = 1'b0;
                        nop_raw      = 1'b1;
                        stall_raw    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    le_pc_raw    = 1'b0;
                    le_if_id_raw = 1'b0;
                    nop_raw      = 1'b1;
                    stall_raw    = 1'b1;
                    cnt_nxt      = cnt - 1'b1;
                    if (cnt == 1) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs take their idle values for as long as clr is held, independent of flush.
    always_comb begin
        FW_A      = fw_a_raw;
        FW_B      = fw_b_raw;
        FW_C      = fw_c_raw;
        LE_PC     = le_pc_raw;
        LE_IF_ID  = le_if_id_raw;
        NOP_ID_EX = nop_raw;
        stall     = stall_raw;
        if (clr) begin
            FW_A      = SEL_RF;
            FW_B      = SEL_RF;
            FW_C      = SEL_RF;
            LE_PC     = 1'b1;
            LE_IF_ID  = 1'b1;
            NOP_ID_EX = 1'b0;
            stall     = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: two instances (1 and 2 load-use bubbles) share one stimulus stream.
module tb_hazard_forwarding_unit;

    localparam int U_N = 4;
    localparam int U_M = 2;
    localparam int U_S = 1;
    localparam int EXF = 1;
    localparam int MEMF = 2;
    localparam int WBF = 3;
    localparam logic [9:0] STL = 10'b0000000011;

    typedef struct packed {
        logic [3:0] rn, rm, rs;
        logic [2:0] use_v;
        logic [3:0] rd;
        logic       rfen, ld, fl;
    } stim_t;

    typedef struct packed {
        logic [9:0] e1;
        logic       c1;
        logic [9:0] e2;
        logic       c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] ID_Rn, ID_Rm, ID_Rs, ID_Rd;
    logic       ID_use_Rn, ID_use_Rm, ID_use_Rs;
    logic       ID_RF_enable, ID_load_instr, flush;

    logic [1:0] fw_a1, fw_b1, fw_c1, fw_a2, fw_b2, fw_c2;
    logic       le_pc1, le_ifid1, nop1, stall1;
    logic       le_pc2, le_ifid2, nop2, stall2;
    logic [9:0] obs1, obs2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign obs1 = {fw_a1, fw_b1, fw_c1, le_pc1, le_ifid1, nop1, stall1};
    assign obs2 = {fw_a2, fw_b2, fw_c2, le_pc2, le_ifid2, nop2, stall2};

    hazard_forwarding_unit #(.REG_W(4), .LOAD_STALL_CYCLES(1)) dut1 (
        .clk(clk), .clr(clr),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rs(ID_Rs),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rs(ID_use_Rs),
        .ID_Rd(ID_Rd), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
        .flush(flush),
        .FW_A(fw_a1), .FW_B(fw_b1), .FW_C(fw_c1),
        .LE_PC(le_pc1), .LE_IF_ID(le_ifid1), .NOP_ID_EX(nop1), .stall(stall1)
    );

    hazard_forwarding_unit #(.REG_W(4), .LOAD_STALL_CYCLES(2)) dut2 (
        .clk(clk), .clr(clr),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rs(ID_Rs),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rs(ID_use_Rs),
        .ID_Rd(ID_Rd), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
        .flush(flush),
        .FW_A(fw_a2), .FW_B(fw_b2), .FW_C(fw_c2),
        .LE_PC(le_pc2), .LE_IF_ID(le_ifid2), .NOP_ID_EX(nop2), .stall(stall2)
    );

    function automatic stim_t st(int rn, int rm, int rs, int u, int rd, int rfen, int ld, int fl);
        stim_t s;
        s.rn    = 4'(rn);
        s.rm    = 4'(rm);
        s.rs    = 4'(rs);
        s.use_v = 3'(u);
        s.rd    = 4'(rd);
        s.rfen  = 1'(rfen);
        s.ld    = 1'(ld);
        s.fl    = 1'(fl);
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [9:0] run_o(int a, int b, int c);
        return {2'(a), 2'(b), 2'(c), 4'b1100};
    endfunction

    function automatic logic [9:0] fl_o(int a, int b, int c);
        return {2'(a), 2'(b), 2'(c), 4'b1110};
    endfunction

    function automatic exp_t ex(logic [9:0] e1, logic c1, logic [9:0] e2, logic c2);
        exp_t x;
        x.e1 = e1;
        x.c1 = c1;
        x.e2 = e2;
        x.c2 = c2;
        return x;
    endfunction

    function automatic exp_t both(logic [9:0] e);
        return ex(e, 1'b1, e, 1'b1);
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        ID_Rn         = s.rn;
        ID_Rm         = s.rm;
        ID_Rs         = s.rs;
        {ID_use_Rn, ID_use_Rm, ID_use_Rs} = s.use_v;
        ID_Rd         = s.rd;
        ID_RF_enable  = s.rfen;
        ID_load_instr = s.ld;
        flush         = s.fl;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        s.push_back(st(0, 0, 0, 0, 5, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(5, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(EXF, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs1 !== x.e1) begin errors++; $display("FAIL reset_pre[%0d] dut1 got %b want %b", i, obs1, x.e1); end
            checks++;
            if (obs2 !== x.e2) begin errors++; $display("FAIL reset_pre[%0d] dut2 got %b want %b", i, obs2, x.e2); end
            @(posedge clk); #1;
        end
        // R5 now sits in MEM; a mid-cycle clr must drop the forward at once.
        #2;
        sb.push_back(both(run_o(0, 0, 0)));
        clr = 1'b1;
        #1;
        x = sb.pop_front();
        checks++;
        if (obs1 !== x.e1) begin errors++; $display("FAIL reset_async dut1 got %b want %b", obs1, x.e1); end
        checks++;
        if (obs2 !== x.e2) begin errors++; $display("FAIL reset_async dut2 got %b want %b", obs2, x.e2); end
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        s.delete(); e.delete();
        s.push_back(st(3, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(5, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs1 !== x.e1) begin errors++; $display("FAIL reset_post[%0d] dut1 got %b want %b", i, obs1, x.e1); end
            checks++;
            if (obs2 !== x.e2) begin errors++; $display("FAIL reset_post[%0d] dut2 got %b want %b", i, obs2, x.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ex_forward();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        repeat (3) begin s.push_back(idle()); e.push_back(both(run_o(0, 0, 0))); end
        s.push_back(st(0, 0, 0, 0, 5, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(5, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(EXF, 0, 0)));
        s.push_back(st(0, 5, 0, U_M, 0, 0, 0, 0)); e.push_back(both(run_o(0, MEMF, 0)));
        s.push_back(st(0, 0, 5, U_S, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, WBF)));
        s.push_back(st(5, 5, 5, 7, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs1 !== x.e1) begin errors++; $display("FAIL ex_forward[%0d] dut1 got %b want %b", i, obs1, x.e1); end
            checks++;
            if (obs2 !== x.e2) begin errors++; $display("FAIL ex_forward[%0d] dut2 got %b want %b", i, obs2, x.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        repeat (3) begin s.push_back(idle()); e.push_back(both(run_o(0, 0, 0))); end
        repeat (3) begin s.push_back(st(0, 0, 0, 0, 2, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0))); end
        s.push_back(st(2, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(EXF, 0, 0)));
        s.push_back(st(2, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(MEMF, 0, 0)));
        s.push_back(st(2, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(WBF, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 15, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 2, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 1, 1, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(1, 2, 15, 7, 0, 0, 0, 0)); e.push_back(both(run_o(EXF, MEMF, WBF)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs1 !== x.e1) begin errors++; $display("FAIL priority[%0d] dut1 got %b want %b", i, obs1, x.e1); end
            checks++;
            if (obs2 !== x.e2) begin errors++; $display("FAIL priority[%0d] dut2 got %b want %b", i, obs2, x.e2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        logic [9:0] m1, m2;
        repeat (3) begin s.push_back(idle()); e.push_back(both(run_o(0, 0, 0))); end
        s.push_back(st(0, 0, 0, 0, 4, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(ex(STL, 1'b0, STL, 1'b0));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(ex(run_o(MEMF, 0, 0), 1'b1, STL, 1'b0));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(WBF, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 7, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 7, U_S, 0, 0, 0, 0)); e.push_back(ex(STL, 1'b0, STL, 1'b0));
        s.push_back(st(0, 0, 7, U_S, 0, 0, 0, 0)); e.push_back(ex(run_o(0, 0, MEMF), 1'b1, STL, 1'b0));
        s.push_back(st(0, 0, 7, U_S, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, WBF)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            m1 = x.c1 ? 10'h3FF : 10'h00F;
            m2 = x.c2 ? 10'h3FF : 10'h00F;
            checks++;
            if ((obs1 & m1) !== (x.e1 & m1)) begin errors++; $display("FAIL load_use[%0d] dut1 got %b want %b", i, obs1 & m1, x.e1 & m1); end
            checks++;
            if ((obs2 & m2) !== (x.e2 & m2)) begin errors++; $display("FAIL load_use[%0d] dut2 got %b want %b", i, obs2 & m2, x.e2 & m2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        logic [9:0] m1, m2;
        repeat (3) begin s.push_back(idle()); e.push_back(both(run_o(0, 0, 0))); end
        s.push_back(st(0, 0, 0, 0, 4, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(4, 0, 0, U_N, 6, 1, 1, 0)); e.push_back(ex(STL, 1'b0, STL, 1'b0));
        s.push_back(st(4, 0, 0, U_N, 6, 1, 1, 0)); e.push_back(ex(run_o(MEMF, 0, 0), 1'b1, STL, 1'b0));
        s.push_back(st(6, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(ex(STL, 1'b0, run_o(0, 0, 0), 1'b1));
        s.push_back(st(6, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(ex(run_o(MEMF, 0, 0), 1'b1, run_o(0, 0, 0), 1'b1));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            m1 = x.c1 ? 10'h3FF : 10'h00F;
            m2 = x.c2 ? 10'h3FF : 10'h00F;
            checks++;
            if ((obs1 & m1) !== (x.e1 & m1)) begin errors++; $display("FAIL back_to_back[%0d] dut1 got %b want %b", i, obs1 & m1, x.e1 & m1); end
            checks++;
            if ((obs2 & m2) !== (x.e2 & m2)) begin errors++; $display("FAIL back_to_back[%0d] dut2 got %b want %b", i, obs2 & m2, x.e2 & m2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        logic [9:0] m1, m2;
        repeat (3) begin s.push_back(idle()); e.push_back(both(run_o(0, 0, 0))); end
        s.push_back(st(0, 0, 0, 0, 4, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(ex(STL, 1'b0, STL, 1'b0));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 1)); e.push_back(both(fl_o(MEMF, 0, 0)));
        s.push_back(st(9, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 4, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 1)); e.push_back(both(fl_o(0, 0, 0)));
        s.push_back(st(4, 0, 0, U_N, 0, 0, 0, 0)); e.push_back(both(run_o(MEMF, 0, 0)));
        s.push_back(st(0, 0, 0, 0, 7, 1, 1, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 7, 0, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, 0)));
        s.push_back(st(0, 0, 7, U_S, 0, 0, 0, 0)); e.push_back(both(run_o(0, 0, MEMF)));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front();
            m1 = x.c1 ? 10'h3FF : 10'h00F;
            m2 = x.c2 ? 10'h3FF : 10'h00F;
            checks++;
            if ((obs1 & m1) !== (x.e1 & m1)) begin errors++; $display("FAIL flush[%0d] dut1 got %b want %b", i, obs1 & m1, x.e1 & m1); end
            checks++;
            if ((obs2 & m2) !== (x.e2 & m2)) begin errors++; $display("FAIL flush[%0d] dut2 got %b want %b", i, obs2 & m2, x.e2 & m2); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        apply(idle(), both(run_o(0, 0, 0)));
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
